// File: rtl/flash_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : flash_write_scheduler
// Description : Sequences one complete JPEG file write onto the single flash
//               write port: kicks the header writer, passes its words
//               through, hands the port to the entropy-coded scan stream,
//               then appends the EOI marker. Counts committed bytes, flags
//               scan overflow / abort, and pulses done at end of file.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in, rst_n          : clock, asynchronous active-low reset
//   start, abort           : one-cycle file start / terminate pulses
//   s_halt                 : flash slave back-pressure (no commit while high)
//   hdr_start, hdr_halt    : control to the header writer
//   hdr_done, hdr_write_*,
//   hdr_d_qual             : header writer word stream
//   scan_valid/data/be/last,
//   scan_ready             : scan word stream handshake
//   m_cmd, write_data,
//   write_be, d_qual       : muxed flash write interface
//   busy, done, error      : status (error is sticky until next start)
//   byte_count             : bytes committed since the last start
// ============================================================================
module flash_write_scheduler #(
    parameter int unsigned MAX_SCAN_WORDS = 65536,
    parameter logic [15:0] EOI_MARKER     = 16'hFFD9,
    parameter logic [1:0]  CMD_WRITE      = 2'b10,
    parameter logic [1:0]  CMD_NOP        = 2'b00
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        s_halt,
    output logic        hdr_start,
    output logic        hdr_halt,
    input  logic        hdr_done,
    input  logic [31:0] hdr_write_data,
    input  logic [3:0]  hdr_write_be,
    input  logic        hdr_d_qual,
    input  logic        scan_valid,
    input  logic [31:0] scan_data,
    input  logic [3:0]  scan_be,
    input  logic        scan_last,
    output logic        scan_ready,
    output logic [1:0]  m_cmd,
    output logic [31:0] write_data,
    output logic [3:0]  write_be,
    output logic        d_qual,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] byte_count
);

    localparam int unsigned        C_CNT_W      = $clog2(MAX_SCAN_WORDS + 1);
    localparam logic [C_CNT_W-1:0] C_SCAN_LIMIT = C_CNT_W'(MAX_SCAN_WORDS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR_KICK = 3'd1,
        S_HDR      = 3'd2,
        S_SCAN     = 3'd3,
        S_EOI      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_error;
    logic [31:0]          r_byte_count;
    logic [C_CNT_W-1:0]   r_scan_cnt;

    logic                 w_hdr_start;
    logic                 w_hdr_halt;
    logic                 w_scan_ready;
    logic [31:0]          w_write_data;
    logic [3:0]           w_write_be;
    logic                 w_d_qual;
    logic                 w_done;
    logic                 w_xfer;
    logic                 w_overflow;
    logic                 w_abort;
    logic                 w_commit;
    logic [2:0]           w_be_bytes;
    logic [C_CNT_W-1:0]   w_scan_cnt_nxt;

    assign w_scan_cnt_nxt = r_scan_cnt + C_CNT_W'(1);
    assign w_abort        = abort && (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Next-state and output decode. Abort only redirects the next state;
    // this cycle's outputs (and any commit they carry) are left intact.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_hdr_start  = 1'b0;
        w_hdr_halt   = 1'b1;
        w_scan_ready = 1'b0;
        w_write_data = 32'h0;
        w_write_be   = 4'h0;
        w_d_qual     = 1'b0;
        w_done       = 1'b0;
        w_xfer       = 1'b0;
        w_overflow   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_HDR_KICK;
                end
            end
            S_HDR_KICK: begin
                w_hdr_start = 1'b1;
                w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_write_data = hdr_write_data;
                w_write_be   = hdr_write_be;
                w_d_qual     = hdr_d_qual;
                w_hdr_halt   = s_halt;
                // The last header word only leaves once the slave takes it.
                if (hdr_done && !s_halt) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_scan_ready = ~s_halt;
                w_xfer       = scan_valid & ~s_halt;
                w_write_data = scan_data;
                if (w_xfer) begin
                    w_write_be = scan_be;
                    if (scan_last) begin
                        w_state_nxt = S_EOI;
                    end else if (w_scan_cnt_nxt == C_SCAN_LIMIT) begin
                        // Scan too long: close the file with EOI anyway.
                        w_overflow  = 1'b1;
                        w_state_nxt = S_EOI;
                    end
                end
            end
            S_EOI: begin
                w_write_data = {EOI_MARKER, 16'h0};
                w_write_be   = 4'b1100;
                if (!s_halt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_commit   = (w_write_be != 4'h0) && !s_halt;
    assign w_be_bytes = {2'b00, w_write_be[0]} + {2'b00, w_write_be[1]}
                      + {2'b00, w_write_be[2]} + {2'b00, w_write_be[3]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Per-file bookkeeping: byte counter, scan word counter, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= 32'h0;
            r_scan_cnt   <= '0;
            r_error      <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_byte_count <= 32'h0;
            r_scan_cnt   <= '0;
            r_error      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_byte_count <= r_byte_count + {29'h0, w_be_bytes};
            end
            if (w_xfer) begin
                r_scan_cnt <= w_scan_cnt_nxt;
            end
            if (w_overflow || w_abort) begin
                r_error <= 1'b1;
            end
        end
    end

    assign hdr_start  = w_hdr_start;
    assign hdr_halt   = w_hdr_halt;
    assign scan_ready = w_scan_ready;
    assign write_data = w_write_data;
    assign write_be   = w_write_be;
    assign d_qual     = w_d_qual;
    assign m_cmd      = (w_write_be != 4'h0) ? CMD_WRITE : CMD_NOP;
    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign error      = r_error;
    assign byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_flash_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_write_scheduler
// Description : Self-checking bench for flash_write_scheduler. A header
//               writer and a scan source are emulated; the expected flash
//               commit stream is queued per file and checked on every
//               commit, with a running byte-count model and directed
//               literal expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_write_scheduler;

    typedef struct packed {
        logic        dq;
        logic        chk_dq;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic        s_halt = 1'b0;
    logic        hdr_done = 1'b0;
    logic [31:0] hdr_write_data = 32'h0;
    logic [3:0]  hdr_write_be = 4'h0;
    logic        hdr_d_qual = 1'b0;
    logic        scan_valid = 1'b0;
    logic [31:0] scan_data = 32'h0;
    logic [3:0]  scan_be = 4'h0;
    logic        scan_last = 1'b0;
    logic        sel = 1'b0;

    // Outputs of the default instance (a) and the MAX_SCAN_WORDS=4 one (b)
    logic a_hdr_start, a_hdr_halt, a_scan_ready, a_d_qual, a_busy, a_done, a_error;
    logic b_hdr_start, b_hdr_halt, b_scan_ready, b_d_qual, b_busy, b_done, b_error;
    logic [1:0]  a_m_cmd, b_m_cmd;
    logic [31:0] a_write_data, b_write_data, a_byte_count, b_byte_count;
    logic [3:0]  a_write_be, b_write_be;

    logic hdr_start, hdr_halt, scan_ready, d_qual, busy, done, error;
    logic [1:0]  m_cmd;
    logic [31:0] write_data, byte_count;
    logic [3:0]  write_be;

    assign hdr_start  = sel ? b_hdr_start  : a_hdr_start;
    assign hdr_halt   = sel ? b_hdr_halt   : a_hdr_halt;
    assign scan_ready = sel ? b_scan_ready : a_scan_ready;
    assign d_qual     = sel ? b_d_qual     : a_d_qual;
    assign busy       = sel ? b_busy       : a_busy;
    assign done       = sel ? b_done       : a_done;
    assign error      = sel ? b_error      : a_error;
    assign m_cmd      = sel ? b_m_cmd      : a_m_cmd;
    assign write_data = sel ? b_write_data : a_write_data;
    assign byte_count = sel ? b_byte_count : a_byte_count;
    assign write_be   = sel ? b_write_be   : a_write_be;

    flash_write_scheduler u_dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .s_halt(s_halt),
        .hdr_start(a_hdr_start), .hdr_halt(a_hdr_halt), .hdr_done(hdr_done),
        .hdr_write_data(hdr_write_data), .hdr_write_be(hdr_write_be), .hdr_d_qual(hdr_d_qual),
        .scan_valid(scan_valid), .scan_data(scan_data), .scan_be(scan_be),
        .scan_last(scan_last), .scan_ready(a_scan_ready),
        .m_cmd(a_m_cmd), .write_data(a_write_data), .write_be(a_write_be), .d_qual(a_d_qual),
        .busy(a_busy), .done(a_done), .error(a_error), .byte_count(a_byte_count)
    );

    flash_write_scheduler #(.MAX_SCAN_WORDS(4)) u_dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .s_halt(s_halt),
        .hdr_start(b_hdr_start), .hdr_halt(b_hdr_halt), .hdr_done(hdr_done),
        .hdr_write_data(hdr_write_data), .hdr_write_be(hdr_write_be), .hdr_d_qual(hdr_d_qual),
        .scan_valid(scan_valid), .scan_data(scan_data), .scan_be(scan_be),
        .scan_last(scan_last), .scan_ready(b_scan_ready),
        .m_cmd(b_m_cmd), .write_data(b_write_data), .write_be(b_write_be), .d_qual(b_d_qual),
        .busy(b_busy), .done(b_done), .error(b_error), .byte_count(b_byte_count)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus state and observation records
    int          cyc = 0;
    int          hdr_n = 0, hdr_i = 0, scan_n = 0, scan_j = 0, abort_cyc = -1;
    logic        hdr_act = 1'b0, scan_last_en = 1'b0, busy_s = 1'b0;
    logic [63:0] halt_mask = 64'h0;
    int          samp_cyc = 0, end_cyc = -1;
    int          hs_cnt = 0, hs_cyc = -1, done_cnt = 0, done_cyc = -1, eoi_cyc = -1;
    int          first_sr = -1, last_sr = -1;
    exp_t        exp_q[$];
    logic [31:0] model_bytes = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_hdr(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dq     = (i == 1);
            e.chk_dq = 1'b1;
            e.be     = (i == n - 1) ? 4'b0011 : 4'hF;
            e.data   = 32'hA000_0000 + 32'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_scan(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dq     = 1'b0;
            e.chk_dq = 1'b0;
            e.be     = 4'hF;
            e.data   = 32'h5C00_0000 + 32'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_eoi();
        exp_t e;
        e.dq = 1'b0; e.chk_dq = 1'b1; e.be = 4'b1100; e.data = 32'hFFD9_0000;
        exp_q.push_back(e);
    endtask

    // Commit-stream and rule checker, one pass per cycle on the falling edge
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_n) begin
            model_bytes = 32'h0;
        end else begin
            chk("m_cmd_rule", 64'(m_cmd), (write_be != 4'h0) ? 64'd2 : 64'd0);
            chk("byte_count", 64'(byte_count), 64'(model_bytes));
            chk("hdr_halt", 64'(hdr_halt), hdr_act ? 64'(s_halt) : 64'd1);
            if (s_halt) chk("scan_ready_halted", 64'(scan_ready), 64'd0);
            if (write_be != 4'h0 && !s_halt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", {28'h0, write_be, write_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_data", 64'(write_data), 64'(e.data));
                    chk("commit_be", 64'(write_be), 64'(e.be));
                    if (e.chk_dq) chk("commit_dqual", 64'(d_qual), 64'(e.dq));
                    model_bytes = model_bytes + 32'($countones(e.be));
                end
                if (write_be == 4'b1100 && write_data == 32'hFFD9_0000) eoi_cyc = cyc;
            end
            if (start) model_bytes = 32'h0;
            if (hdr_start) begin hs_cnt++; hs_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (scan_ready) begin
                if (first_sr < 0) first_sr = cyc;
                last_sr = cyc;
            end
        end
    end

    task automatic drive_inputs();
        s_halt         = (cyc < 64) ? halt_mask[cyc] : 1'b0;
        abort          = (cyc == abort_cyc);
        hdr_write_data = 32'hA000_0000 + 32'(hdr_i);
        hdr_write_be   = (hdr_i == hdr_n - 1) ? 4'b0011 : 4'hF;
        hdr_d_qual     = (hdr_i == 1);
        hdr_done       = hdr_act && (hdr_i == hdr_n - 1);
        scan_valid     = (scan_j < scan_n);
        scan_data      = 32'h5C00_0000 + 32'(scan_j);
        scan_be        = 4'hF;
        scan_last      = scan_last_en && (scan_j == scan_n - 1);
    endtask

    task automatic step();
        logic hs, hadv, sadv;
        @(negedge clk_in);
        hs       = hdr_start;
        hadv     = hdr_act && !hdr_halt;
        sadv     = scan_valid && scan_ready;
        busy_s   = busy;
        samp_cyc = cyc;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        if (hadv) begin
            if (hdr_i == hdr_n - 1) hdr_act = 1'b0;
            else hdr_i++;
        end
        if (hs) begin hdr_act = 1'b1; hdr_i = 0; end
        if (sadv) scan_j++;
        cyc++;
        drive_inputs();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_write_be"}, 64'(write_be), 64'd0);
        chk({tag, "_write_data"}, 64'(write_data), 64'd0);
        chk({tag, "_m_cmd"}, 64'(m_cmd), 64'd0);
        chk({tag, "_dqual"}, 64'(d_qual), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_byte_count"}, 64'(byte_count), 64'd0);
        chk({tag, "_hdr_start"}, 64'(hdr_start), 64'd0);
        chk({tag, "_scan_ready"}, 64'(scan_ready), 64'd0);
    endtask

    // Runs one file from a start pulse (called at posedge+1 with DUT idle)
    task automatic run_file(input int hn, input int sn, input logic last_en,
                            input logic [63:0] mask, input int abort_c, input int rst_c);
        logic fin;
        hdr_n = hn; hdr_i = 0; hdr_act = 1'b0;
        scan_n = sn; scan_j = 0; scan_last_en = last_en;
        halt_mask = mask; abort_cyc = abort_c;
        hs_cnt = 0; hs_cyc = -1; done_cnt = 0; done_cyc = -1; eoi_cyc = -1;
        first_sr = -1; last_sr = -1; end_cyc = -1;
        cyc = 0;
        drive_inputs();
        start = 1'b1;
        fin = 1'b0;
        while (!fin) begin
            if (cyc == rst_c) begin
                #2;
                chk("eoi_held_be", 64'(write_be), 64'hC);
                chk("eoi_cmd_under_halt", 64'(m_cmd), 64'd2);
                rst_n = 1'b0;
                #1;
                check_reset("async_rst");
                @(posedge clk_in);
                #1;
                rst_n = 1'b1;
                exp_q.delete();
                fin = 1'b1;
            end else begin
                step();
                if (samp_cyc >= 1 && !busy_s) begin
                    end_cyc = samp_cyc;
                    fin = 1'b1;
                end else if (cyc >= 300) begin
                    chk("file_timeout", 64'(cyc), 64'd0);
                    fin = 1'b1;
                end
            end
        end
        halt_mask = 64'h0; abort_cyc = -1;
        s_halt = 1'b0; abort = 1'b0;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] m;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check_reset("por");
        @(posedge clk_in);
        #1 rst_n = 1'b1;

        // Nominal: 23 header words, 10 scan words, no halt
        push_hdr(23); push_scan(10); push_eoi();
        run_file(23, 10, 1'b1, 64'h0, -1, -1);
        chk("nom_hdr_start_cnt", 64'(hs_cnt), 64'd1);
        chk("nom_hdr_start_cyc", 64'(hs_cyc), 64'd1);
        chk("nom_eoi_cyc", 64'(eoi_cyc), 64'd35);
        chk("nom_done_cyc", 64'(done_cyc), 64'd36);
        chk("nom_bytes", 64'(byte_count), 64'd132);
        chk("nom_error", 64'(error), 64'd0);

        // Back-pressure in HDR, SCAN and EOI
        m = 64'h0;
        m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1;
        m[30] = 1'b1; m[31] = 1'b1; m[32] = 1'b1;
        m[41] = 1'b1; m[42] = 1'b1; m[43] = 1'b1;
        push_hdr(23); push_scan(10); push_eoi();
        run_file(23, 10, 1'b1, m, -1, -1);
        chk("bp_eoi_cyc", 64'(eoi_cyc), 64'd44);
        chk("bp_done_cyc", 64'(done_cyc), 64'd45);
        chk("bp_done_cnt", 64'(done_cnt), 64'd1);
        chk("bp_bytes", 64'(byte_count), 64'd132);

        // hdr_done held under halt
        m = 64'h0;
        m[4] = 1'b1; m[5] = 1'b1;
        push_hdr(3); push_scan(2); push_eoi();
        run_file(3, 2, 1'b1, m, -1, -1);
        chk("hdh_first_scan_ready", 64'(first_sr), 64'd7);
        chk("hdh_done_cyc", 64'(done_cyc), 64'd10);
        chk("hdh_bytes", 64'(byte_count), 64'd20);

        // Abort in SCAN coincident with the second scan word
        push_hdr(3); push_scan(2);
        run_file(3, 5, 1'b1, 64'h0, 6, -1);
        chk("abort_idle_cyc", 64'(end_cyc), 64'd7);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_error", 64'(error), 64'd1);
        chk("abort_write_be", 64'(write_be), 64'd0);
        chk("abort_bytes", 64'(byte_count), 64'd18);
        push_hdr(3); push_scan(2); push_eoi();
        run_file(3, 2, 1'b1, 64'h0, -1, -1);
        chk("post_abort_error", 64'(error), 64'd0);
        chk("post_abort_done_cyc", 64'(done_cyc), 64'd8);
        chk("post_abort_bytes", 64'(byte_count), 64'd20);

        // Asynchronous reset while EOI is held by back-pressure
        m = 64'h0;
        m[7] = 1'b1; m[8] = 1'b1; m[9] = 1'b1;
        push_hdr(3); push_scan(2); push_eoi();
        run_file(3, 2, 1'b1, m, -1, 8);
        push_hdr(3); push_scan(2); push_eoi();
        run_file(3, 2, 1'b1, 64'h0, -1, -1);
        chk("post_rst_done_cnt", 64'(done_cnt), 64'd1);
        chk("post_rst_bytes", 64'(byte_count), 64'd20);

        // Scan overflow on the MAX_SCAN_WORDS=4 instance
        sel = 1'b1;
        rst_n = 1'b0;
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        push_hdr(3); push_scan(4); push_eoi();
        run_file(3, 6, 1'b0, 64'h0, -1, -1);
        chk("ovf_accepted", 64'(scan_j), 64'd4);
        chk("ovf_last_ready", 64'(last_sr), 64'd8);
        chk("ovf_eoi_cyc", 64'(eoi_cyc), 64'd9);
        chk("ovf_done_cyc", 64'(done_cyc), 64'd10);
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_bytes", 64'(byte_count), 64'd28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_write_scheduler.md
Name: flash_write_scheduler

Overview:
- Sequences one complete JPEG file write to the flash master port.
- Starts the header writer, hands the shared write port to the entropy-coded scan stream, then appends the EOI marker.
- Muxes data, byte enables and command from the active source onto the single flash write interface, and routes s_halt back-pressure to that source.
- Counts bytes committed, reports completion, and enforces a scan-length limit.

Parameters:
- MAX_SCAN_WORDS, 65536: maximum scan words accepted per file; exceeding it forces EOI and sets error.
- EOI_MARKER, 16'hFFD9: end-of-image marker written after the scan.
- CMD_WRITE, 2'b10: m_cmd value while a write is driven.
- CMD_NOP, 2'b00: m_cmd value otherwise.

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse, begin a file; ignored unless idle
- abort  in  1  one-cycle pulse, terminate the current file
- s_halt  in  1  flash slave back-pressure; no data is committed in a cycle where it is high
- hdr_start  out  1  one-cycle start pulse to the header writer
- hdr_halt  out  1  halt to the header writer
- hdr_done  in  1  pulse, coincident with the header writer's last word
- hdr_write_data  in  32  header word
- hdr_write_be  in  4  header byte enables
- hdr_d_qual  in  1  header filename-qualifier flag
- scan_valid  in  1  scan word available
- scan_data  in  32  scan word
- scan_be  in  4  scan byte enables
- scan_last  in  1  final scan word
- scan_ready  out  1  scheduler accepts the scan word
- m_cmd  out  2  flash command
- write_data  out  32  flash write data
- write_be  out  4  flash byte enables; bit3 selects write_data[31:24]
- d_qual  out  1  filename-qualifier flag to flash
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of file
- error  out  1  sticky: scan overflow or abort; cleared by start
- byte_count  out  32  bytes committed since the last start

Behaviour:
- Reset values (rst_n low, async): state=IDLE; hdr_start=0; scan_ready=0; write_be=0; write_data=0; m_cmd=CMD_NOP; d_qual=0; done=0; error=0; byte_count=0; scan word counter=0.
- States: IDLE, HDR_KICK, HDR, SCAN, EOI, DONE.
- IDLE:
  - write_be=0, hdr_halt=1.
  - On start: byte_count<=0, error<=0, go to HDR_KICK.
- HDR_KICK:
  - hdr_start=1 for this one cycle; write_be=0.
  - Go to HDR next cycle.
- HDR:
  - Combinational pass-through: write_data/write_be/d_qual = hdr_write_data/hdr_write_be/hdr_d_qual; hdr_halt=s_halt.
  - When hdr_done=1 and s_halt=0: the last header word commits this cycle; go to SCAN.
  - When hdr_done=1 and s_halt=1: remain in HDR, word still pending.
- SCAN:
  - hdr_halt=1; scan_ready = ~s_halt.
  - Transfer = scan_valid & scan_ready. On a transfer, write_data=scan_data and write_be=scan_be; otherwise write_be=0.
  - On transfer with scan_last: go to EOI.
  - On transfer where the word counter reaches MAX_SCAN_WORDS without scan_last: set error, go to EOI. Further scan words are not accepted (scan_ready=0).
- EOI:
  - write_data={EOI_MARKER,16'h0}, write_be=4'b1100, d_qual=0.
  - Held until s_halt=0; on that cycle go to DONE.
- DONE:
  - done=1 for one cycle; write_be=0.
  - Go to IDLE.
- m_cmd = CMD_WRITE when write_be!=0, else CMD_NOP. This is combinational and may be high while s_halt is high; the word commits on the first cycle s_halt is low.
- byte_count increments by popcount(write_be) on every cycle with write_be!=0 and s_halt=0. The 32-bit counter wraps silently.
- abort in any non-IDLE state:
  - Next state IDLE; error<=1; no EOI written; done not pulsed.
  - Outputs in the abort cycle are unchanged. From the next cycle write_be=0.
- start while busy: ignored. start coincident with abort in IDLE: start wins.
- Reset mid-file: immediate return to IDLE with all outputs at reset values.

Test Plan:
- Nominal file:
  - Stimulus: start; header of 23 words ending with hdr_done; 10 scan words with be=4'hF, last on word 10; no halt.
  - Required: hdr_start pulses exactly once, 1 cycle after start; EOI word FFD90000 with be=1100; done pulses 1 cycle after EOI; byte_count = header bytes + 40 + 2.
- Back-pressure:
  - Stimulus: s_halt high for 3 cycles during HDR, SCAN and EOI.
  - Required: hdr_halt follows s_halt in HDR; scan_ready=0 while halted; EOI held; byte_count unchanged while halted; final count equals the no-halt case.
- hdr_done under halt:
  - Stimulus: hdr_done asserted while s_halt=1 for 2 cycles.
  - Required: stays in HDR; transition to SCAN only on the cycle s_halt falls.
- Scan overflow:
  - Stimulus: MAX_SCAN_WORDS=4; 6 scan words, no scan_last.
  - Required: exactly 4 accepted; scan_ready=0 afterwards; EOI written; error=1; done pulses.
- Abort in SCAN after 2 words:
  - Required: IDLE next cycle; write_be=0; error=1; no done; subsequent start clears error and runs a nominal file.
- Async reset mid-EOI:
  - Stimulus: assert rst_n low mid-cycle during EOI.
  - Required: all outputs at reset values immediately, without waiting for a clk_in edge; start works afterwards.
